// File: rtl/bullet_pkg.sv
// Shared bullet types, fixed-point layout and screen limits.
// The axis_step helper advances one axis and reflects it at the playfield edge.
package bullet_pkg;

   localparam int FRAC_BITS    = 6;
   localparam int POS_W        = 16;

   localparam int SCREEN_X_MIN = 0;
   localparam int SCREEN_X_MAX = 639;
   localparam int SCREEN_Y_MIN = 0;
   localparam int SCREEN_Y_MAX = 479;

   typedef logic        [POS_W-1:0] pos_t;
   typedef logic signed [POS_W-1:0] vel_t;

   typedef struct packed {
      pos_t pos;
      vel_t vel;
   } axis_t;

   // Two guard bits make a step below zero show up as a negative integer part.
   function automatic axis_t axis_step(input pos_t pos, input vel_t vel,
                                       input int lo, input int hi);
      logic signed [POS_W+1:0] nxt;
      int                      ipart;
      axis_t                   r;
      nxt   = $signed({2'b00, pos}) + $signed({{2{vel[POS_W-1]}}, vel});
      ipart = int'(nxt >>> FRAC_BITS);
      if (ipart < lo || ipart > hi) begin
         r.pos = pos;
         r.vel = -vel;
      end else begin
         r.pos = nxt[POS_W-1:0];
         r.vel = vel;
      end
      return r;
   endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: active flag, 10.6 position, velocity, lifetime counter
// and edge reflection. Spawn is only ever issued to an inactive slot.
module bullet_slot
   import bullet_pkg::*;
#(
   parameter int unsigned LIFETIME = 300,
   parameter int          X_MIN    = SCREEN_X_MIN,
   parameter int          X_MAX    = SCREEN_X_MAX,
   parameter int          Y_MIN    = SCREEN_Y_MIN,
   parameter int          Y_MAX    = SCREEN_Y_MAX
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spawn,
   input  logic       hit,
   input  pos_t       spawn_x,
   input  pos_t       spawn_y,
   input  vel_t       spawn_vx,
   input  vel_t       spawn_vy,
   output logic       active,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y
);

   localparam int unsigned LW = $clog2(LIFETIME + 1);

   logic          active_q, active_d;
   pos_t          x_q, x_d, y_q, y_d;
   vel_t          vx_q, vx_d, vy_q, vy_d;
   logic [LW-1:0] life_q, life_d;
   axis_t         step_x, step_y;

   always_comb begin
      active_d = active_q;
      x_d      = x_q;
      y_d      = y_q;
      vx_d     = vx_q;
      vy_d     = vy_q;
      life_d   = life_q;
      step_x   = axis_step(x_q, vx_q, X_MIN, X_MAX);
      step_y   = axis_step(y_q, vy_q, Y_MIN, Y_MAX);
      if (spawn) begin
         active_d = 1'b1;
         x_d      = spawn_x;
         y_d      = spawn_y;
         vx_d     = spawn_vx;
         vy_d     = spawn_vy;
         life_d   = LW'(LIFETIME - 1);
      end else if (active_q) begin
         if (hit || life_q == '0) begin
            active_d = 1'b0;
         end else begin
            life_d = life_q - 1'b1;
            x_d    = step_x.pos;
            vx_d   = step_x.vel;
            y_d    = step_y.pos;
            vy_d   = step_y.vel;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         vx_q     <= '0;
         vy_q     <= '0;
         life_q   <= '0;
      end else begin
         active_q <= active_d;
         x_q      <= x_d;
         y_q      <= y_d;
         vx_q     <= vx_d;
         vy_q     <= vy_d;
         life_q   <= life_d;
      end
   end

   assign active = active_q;
   assign pos_x  = x_q[POS_W-1:FRAC_BITS];
   assign pos_y  = y_q[POS_W-1:FRAC_BITS];

endmodule

// File: rtl/bullet_ctrl.sv
// Bullet pool controller: fire edge detection, cooldown, lowest-free-slot
// allocation and a generate loop of bullet_slot instances.
module bullet_ctrl
   import bullet_pkg::*;
#(
   parameter int unsigned N_BULLETS   = 4,
   parameter int unsigned LIFETIME    = 300,
   parameter int unsigned COOLDOWN    = 16,
   parameter int unsigned SPEED_SHIFT = 0,
   parameter int          X_MIN       = SCREEN_X_MIN,
   parameter int          X_MAX       = SCREEN_X_MAX,
   parameter int          Y_MIN       = SCREEN_Y_MIN,
   parameter int          Y_MAX       = SCREEN_Y_MAX
) (
   input  logic                      frame_clk,
   input  logic                      Reset_n,
   input  logic                      ShootBullet,
   input  logic [9:0]                TankX,
   input  logic [9:0]                TankY,
   input  logic signed [7:0]         Sin,
   input  logic signed [7:0]         Cos,
   input  logic [N_BULLETS-1:0]      HitMask,
   output logic [10*N_BULLETS-1:0]   BulletX,
   output logic [10*N_BULLETS-1:0]   BulletY,
   output logic [N_BULLETS-1:0]      BulletActive
);

   localparam int unsigned   CW      = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
   localparam logic [CW-1:0] CD_LOAD = (COOLDOWN > 0) ? CW'(COOLDOWN - 1) : '0;

   logic                 prev_shoot_q, prev_shoot_d;
   logic [CW-1:0]        cooldown_q, cooldown_d;
   logic [N_BULLETS-1:0] free_onehot, spawn_vec;
   logic                 request, slot_free, fire;
   pos_t                 x_spawn, y_spawn;
   vel_t                 vx_spawn, vy_spawn;

   always_comb begin
      request      = ShootBullet & ~prev_shoot_q;
      prev_shoot_d = ShootBullet;
      free_onehot  = '0;
      slot_free    = 1'b0;
      // Only the pre-edge active flags count; a slot being hit this edge is still busy.
      for (int unsigned i = 0; i < N_BULLETS; i++) begin
         if (!BulletActive[i] && !slot_free) begin
            free_onehot[i] = 1'b1;
            slot_free      = 1'b1;
         end
      end
      fire       = request && (cooldown_q == '0) && slot_free;
      spawn_vec  = fire ? free_onehot : '0;
      cooldown_d = cooldown_q;
      if (fire) begin
         cooldown_d = CD_LOAD;
      end else if (cooldown_q != '0) begin
         cooldown_d = cooldown_q - 1'b1;
      end
   end

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         prev_shoot_q <= 1'b0;
         cooldown_q   <= '0;
      end else begin
         prev_shoot_q <= prev_shoot_d;
         cooldown_q   <= cooldown_d;
      end
   end

   assign x_spawn  = {TankX, {FRAC_BITS{1'b0}}};
   assign y_spawn  = {TankY, {FRAC_BITS{1'b0}}};
   assign vx_spawn = vel_t'({{8{Cos[7]}}, Cos}) <<< SPEED_SHIFT;
   assign vy_spawn = -(vel_t'({{8{Sin[7]}}, Sin}) <<< SPEED_SHIFT);

   for (genvar g = 0; g < N_BULLETS; g++) begin : g_slot
      bullet_slot #(
         .LIFETIME (LIFETIME),
         .X_MIN    (X_MIN),
         .X_MAX    (X_MAX),
         .Y_MIN    (Y_MIN),
         .Y_MAX    (Y_MAX)
      ) u_slot (
         .clk      (frame_clk),
         .rst_n    (Reset_n),
         .spawn    (spawn_vec[g]),
         .hit      (HitMask[g]),
         .spawn_x  (x_spawn),
         .spawn_y  (y_spawn),
         .spawn_vx (vx_spawn),
         .spawn_vy (vy_spawn),
         .active   (BulletActive[g]),
         .pos_x    (BulletX[10*g +: 10]),
         .pos_y    (BulletY[10*g +: 10])
      );
   end

endmodule

// File: doc/bullet_ctrl.md
Name: bullet_ctrl

Overview:
- Consumer end of the tank's fire/pose interface: takes the tank's ShootBullet request, position and the sin/cos of its current Angle.
- Spawns bullets into a small fixed pool and advances each bullet once per frame along its launch direction.
- Reflects bullets off the screen edges and retires them on lifetime expiry or on a hit reported by the collision logic.
- Outputs per-slot screen coordinates and active flags to the renderer and to the collision logic.

Parameters:
- N_BULLETS, 4, number of bullet slots in the pool.
- LIFETIME, 300, frames a bullet stays active after spawn.
- COOLDOWN, 16, frames after a spawn during which further fire requests are ignored.
- SPEED_SHIFT, 0, left shift applied to the sin/cos velocity (speed = 2^SPEED_SHIFT px/frame at unit vector).
- X_MIN / X_MAX, 0 / 639, horizontal playfield limits (integer px).
- Y_MIN / Y_MAX, 0 / 479, vertical playfield limits (integer px).

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- ShootBullet  in  1  fire request level from the tank; a rising edge is a request.
- TankX  in  10  tank centre X, unsigned px.
- TankY  in  10  tank centre Y, unsigned px.
- Sin  in  8  signed Q1.6 sine of the tank Angle (64 = +1.0).
- Cos  in  8  signed Q1.6 cosine of the tank Angle.
- HitMask  in  N_BULLETS  bit i = slot i has hit something this frame.
- BulletX  out  10*N_BULLETS  slot i X position at bits [10i+9:10i].
- BulletY  out  10*N_BULLETS  slot i Y position, same packing as BulletX.
- BulletActive  out  N_BULLETS  bit i = slot i is in flight.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - all slots inactive; positions, velocities and lifetime counters cleared to 0.
  - cooldown counter 0; stored previous ShootBullet value 0.
  - BulletX, BulletY and BulletActive all read 0.
- Fire detection: a request is the rising edge ShootBullet & ~prev_shoot, with prev_shoot registered every frame.
- Spawn:
  - Occurs when a request arrives, cooldown==0 and at least one slot is free.
  - The target is the lowest-index slot with BulletActive=0 at that edge; a slot cleared by HitMask on the same edge does not count as free.
  - The slot is written at the request edge:
    - position = {TankX,6'b0}, {TankY,6'b0} in 16-bit fixed point (10.6).
    - vx = sext(Cos)<<SPEED_SHIFT, vy = -(sext(Sin)<<SPEED_SHIFT), both 16-bit signed.
    - life = LIFETIME-1; active = 1.
  - Cooldown loads COOLDOWN-1 at the spawn edge and decrements to 0, one per frame.
  - A request with no free slot or cooldown!=0 is dropped silently and does not load the cooldown.
- Per-slot update, each edge, active slot, in priority order:
  1. HitMask[i]=1 -> active=0, position held.
  2. Else life==0 -> active=0.
  3. Else life--, then move:
     - nx = x+vx. If nx integer part < X_MIN or > X_MAX (signed compare, so underflow below 0 counts), set vx=-vx and hold x; otherwise x=nx.
     - Y is handled the same way, independently. A corner hit flips both components.
- Latency: a spawned bullet shows the tank position on the output at the request edge and first moves on the next edge.
- Bullet lifetime: active for exactly LIFETIME frames (LIFETIME edges after spawn, active drops).
- Inactive slots: retain their last position; consumers must gate on BulletActive.
- Outputs: BulletX/Y are the integer part pos[15:6], registered, with no combinational path from inputs.
- Simultaneous events:
  - Spawn and hit on different slots proceed independently.
  - HitMask on an inactive slot is ignored.
- Reset mid-flight: all bullets vanish immediately (asynchronous reset).

Decomposition:
- Package bullet_pkg holds:
  - FRAC_BITS=6, the fixed-point position type (16-bit), the signed velocity type (16-bit).
  - screen limit constants, shared with the tank modules.
- Sub-module bullet_slot: one slot's active flag, position, velocity, lifetime counter and bounce logic, with spawn/hit inputs. It is instantiated N_BULLETS times by a generate loop.
- The top level holds edge detection, cooldown and the lowest-free-slot priority encoder.

Test Plan:
- Reset -> BulletActive=0000, BulletX=BulletY=0. Release reset and hold ShootBullet=0 for 20 frames -> no change.
- TankX=320, TankY=240, Cos=64, Sin=0, one ShootBullet pulse -> slot0 active at (320,240) on the request edge; after 10 more frames (330,240). Sin=64, Cos=0 -> Y decreases 1 px/frame.
- Spawn at X=637, Cos=64 -> X sequence over successive edges 637, 638, 639, 639 (vx flips), 638, 637.
- Four requests spaced 20 frames apart -> slots 0..3 active in order; a fifth request -> dropped, no slot changes. A second edge 5 frames after a spawn with COOLDOWN=16 -> ignored.
- Single bullet, no hits -> BulletActive[0] high for exactly 300 frames. With 4 active, HitMask=0010 for one frame -> only slot1 clears next edge; the next request refills slot1.
- Reset_n asserted low mid-frame with 3 bullets active -> all outputs 0 immediately, without waiting for a clock edge.
